xt_ram_bridge: RTL and testbench
================================

Name: xt_ram_bridge

Overview:
Downstream consumer of the chipset's system-bus memory strobes. It decodes conventional RAM (below RAM_TOP_ADDR) and returns `ram_address_select_n` and read data to the chipset's data-bus mux. It converts each ISA-style memory read/write into a single req/ack transaction on the board memory port. While the transaction is outstanding it stretches the bus cycle by pulling `io_channel_ready` low.

Parameters:
- RAM_TOP_ADDR, 20'hA0000: first address not served (640 KB conventional RAM).
- TIMEOUT_CYCLES, 255: clock cycles waited for mem_ack before forcing completion; range 2..255.

Ports:
- clock, in, 1: system clock; the same clock as the chipset bus logic.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, 20: latched system address.
- data_bus, in, 8: system data bus; carries write data.
- memory_read_n, in, 1: MEMR strobe.
- memory_write_n, in, 1: MEMW strobe.
- dma0_acknowledge_n, in, 1: DMA ch0 acknowledge; low marks a refresh cycle.
- ram_address_select_n, out, 1: low when this block owns the current memory address.
- ram_data_out, out, 8: read data to the chipset mux.
- io_channel_ready, out, 1: low stretches the bus cycle.
- mem_req, out, 1: memory port request.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, 20: memory port address.
- mem_wdata, out, 8: memory port write data.
- mem_ack, in, 1: one-cycle completion pulse from the memory port.
- mem_rdata, in, 8: read data, valid in the mem_ack cycle.
- timeout_error, out, 1: sticky flag; set when any transaction times out.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low; port names are clock and reset_n.
- Reset values:
  - state IDLE; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0.
  - ram_data_out 8'h00; timeout_error 0; timeout counter 0.
  - Previous-strobe registers 1.
- Decode (combinational): sel = (address < RAM_TOP_ADDR) & dma0_acknowledge_n. ram_address_select_n = ~sel.
- Start condition:
  - start = IDLE & sel & (falling edge of memory_read_n or memory_write_n).
  - A falling edge is the previous registered value 1 and the current value 0.
- io_channel_ready (combinational) = ~(start | state==REQ). It is low in the start cycle, so the chipset sees a wait with zero latency.
- IDLE:
  - On start: latch mem_addr=address, mem_we=~memory_write_n, mem_wdata=data_bus; set mem_req=1; clear the counter; go to REQ.
  - If both strobes fall together, treat it as a write.
  - Out-of-range addresses and refresh cycles (dma0_acknowledge_n=0) never start a transaction; io_channel_ready stays 1.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. The counter increments each cycle.
  - On mem_ack: mem_req<=0. For a read, ram_data_out<=mem_rdata. Go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 without mem_ack: mem_req<=0, ram_data_out<=8'hFF on a read, timeout_error<=1, go to RELEASE.
  - If mem_ack arrives in that same cycle, ack wins and no error is flagged.
  - A strobe releasing early does not abort the transaction; it completes normally.
- RELEASE: wait until memory_read_n=1 and memory_write_n=1, then go to IDLE. Any mem_ack received outside REQ is ignored.
- ram_data_out holds its value until the next completed read.
- Earliest back-to-back: a new start is possible 2 cycles after ack (RELEASE then IDLE) if the strobes are already high.
- timeout_error clears only on reset.
- Reset during REQ: mem_req drops immediately (asynchronously) and state returns to IDLE. A later mem_ack is ignored.

Test Plan:
- Reset, then idle: with reset_n=0, mem_req=0, io_channel_ready=1, ram_data_out=00, timeout_error=0. After release, with no strobes, all outputs stay at these values.
- Read: MEMR falls at address 20'h12345; mem_ack arrives 3 cycles later with mem_rdata=8'h5A.
  - Required: mem_req=1, mem_we=0, mem_addr=12345.
  - io_channel_ready is low from the strobe-fall cycle until the ack cycle.
  - ram_data_out=5A the cycle after ack; ram_address_select_n=0 throughout.
- Write: MEMW falls at 20'h9FFFF with data_bus=8'hC3. Required: mem_we=1, mem_addr=9FFFF, mem_wdata=C3. After ack, ram_data_out is unchanged.
- No access: MEMR at 20'hA0000, then MEMR at 20'h00400 with dma0_acknowledge_n=0. Required: ram_address_select_n=1, no mem_req, io_channel_ready=1.
- Timeout: MEMR in range and mem_ack never arrives. Required: mem_req drops after TIMEOUT_CYCLES cycles, ram_data_out=FF, timeout_error=1. On a following read acked with 8'h11, ram_data_out=11 and timeout_error stays 1.
- Mid-operation events:
  - Early strobe release: MEMR rises during REQ and ack comes 2 cycles later. Required: the ack completes the read, then the block goes IDLE.
  - Reset during REQ: reset_n pulsed low. Required: mem_req=0 immediately, and a later mem_ack produces no data change.

Source files
------------

// File: rtl/xt_ram_bridge.sv
// Bridges ISA-style MEMR/MEMW strobes for conventional RAM onto a req/ack memory port,
// holding io_channel_ready low while the memory transaction is outstanding.
module xt_ram_bridge #(
    parameter logic [19:0] RAM_TOP_ADDR   = 20'hA0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  data_bus,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        dma0_acknowledge_n,
    output logic        ram_address_select_n,
    output logic [7:0]  ram_data_out,
    output logic        io_channel_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_error
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             read_prev;
    logic             write_prev;
    logic             sel;
    logic             strobe_fall;
    logic             start;

    // Address decode and zero-latency wait request in the strobe-fall cycle
    always_comb begin
        sel                  = (address < RAM_TOP_ADDR) & dma0_acknowledge_n;
        strobe_fall          = (read_prev & ~memory_read_n) | (write_prev & ~memory_write_n);
        start                = (state == IDLE) & sel & strobe_fall;
        ram_address_select_n = ~sel;
        io_channel_ready     = ~(start | (state == REQ));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            count         <= '0;
            read_prev     <= 1'b1;
            write_prev    <= 1'b1;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            ram_data_out  <= 8'h00;
            timeout_error <= 1'b0;
        end else begin
            read_prev  <= memory_read_n;
            write_prev <= memory_write_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= address;
                        mem_we    <= ~memory_write_n;
                        mem_wdata <= data_bus;
                        mem_req   <= 1'b1;
                        count     <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    count <= count + CNT_W'(1);
                    // Ack takes priority over a timeout landing in the same cycle
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) ram_data_out <= mem_rdata;
                        state <= RELEASE;
                    end else if (count == CNT_LAST) begin
                        mem_req       <= 1'b0;
                        timeout_error <= 1'b1;
                        if (!mem_we) ram_data_out <= 8'hFF;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (memory_read_n && memory_write_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xt_ram_bridge.sv
// Randomized bus-cycle bench for xt_ram_bridge with a transaction-level reference model.
module tb_xt_ram_bridge;

    localparam int unsigned T = 255;
    localparam logic [19:0] TOP = 20'hA0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] address = '0;
    logic [7:0]  data_bus = '0;
    logic        memory_read_n = 1'b1;
    logic        memory_write_n = 1'b1;
    logic        dma0_acknowledge_n = 1'b1;
    logic        ram_address_select_n;
    logic [7:0]  ram_data_out;
    logic        io_channel_ready;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        timeout_error;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_rdata = 8'h00;
    logic       exp_terr = 1'b0;

    xt_ram_bridge #(.RAM_TOP_ADDR(TOP), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .data_bus(data_bus),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .dma0_acknowledge_n(dma0_acknowledge_n), .ram_address_select_n(ram_address_select_n),
        .ram_data_out(ram_data_out), .io_channel_ready(io_channel_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_rdy"}, 32'(io_channel_ready), 32'd1);
        check_eq({tag, "_rdata"}, 32'(ram_data_out), 32'(exp_rdata));
        check_eq({tag, "_terr"}, 32'(timeout_error), 32'(exp_terr));
    endtask

    // One complete bus cycle; d = REQ cycle index of the ack (>= T means never acked)
    task automatic bus_access(input logic [19:0] a, input logic [7:0] wd, input logic wr,
                              input logic both, input logic dack, input int d,
                              input logic [7:0] rd, input logic early);
        logic sel_e, we_e, acked;
        int   last;
        sel_e = (a < TOP) && dack;
        we_e  = wr || both;
        address = a;
        data_bus = wd;
        dma0_acknowledge_n = dack;
        if (wr || both) memory_write_n = 1'b0;
        if (!wr || both) memory_read_n = 1'b0;
        #3;
        check_eq("start_seln", 32'(ram_address_select_n), 32'(!sel_e));
        check_eq("start_rdy", 32'(io_channel_ready), 32'(!sel_e));
        check_eq("start_req", 32'(mem_req), 32'd0);
        step();
        if (!sel_e) begin
            check_eq("nosel_req", 32'(mem_req), 32'd0);
            check_eq("nosel_rdy", 32'(io_channel_ready), 32'd1);
        end else begin
            acked = (d < int'(T));
            last  = acked ? d : int'(T) - 1;
            for (int k = 0; k <= last; k++) begin
                mem_ack   = (k == d);
                mem_rdata = (k == d) ? rd : 8'($urandom);
                if (early && k == 1) begin
                    memory_read_n = 1'b1;
                    memory_write_n = 1'b1;
                end
                #3;
                if (k == 0 || k == last) begin
                    check_eq("req_req", 32'(mem_req), 32'd1);
                    check_eq("req_we", 32'(mem_we), 32'(we_e));
                    check_eq("req_addr", 32'(mem_addr), 32'(a));
                    if (we_e) check_eq("req_wdata", 32'(mem_wdata), 32'(wd));
                    check_eq("req_rdy", 32'(io_channel_ready), 32'd0);
                    check_eq("req_seln", 32'(ram_address_select_n), 32'(!sel_e && !early));
                end
                step();
            end
            if (acked && !we_e) exp_rdata = rd;
            if (!acked) begin
                exp_terr = 1'b1;
                if (!we_e) exp_rdata = 8'hFF;
            end
            // A stray ack while releasing must be ignored
            mem_ack = 1'b1;
            mem_rdata = 8'($urandom);
            #3;
            check_idle_outputs("done");
            step();
            mem_ack = 1'b0;
        end
        memory_read_n = 1'b1;
        memory_write_n = 1'b1;
        step();
        step();
        check_idle_outputs("after");
    endtask

    initial begin
        #3;
        check_idle_outputs("rst");
        #10 reset_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        check_idle_outputs("idle");
        check_eq("idle_seln", 32'(ram_address_select_n), 32'd0);

        bus_access(20'h12345, 8'h00, 1'b0, 1'b0, 1'b1, 3, 8'h5A, 1'b0);
        check_eq("read_5a", 32'(ram_data_out), 32'h5A);
        bus_access(20'h9FFFF, 8'hC3, 1'b1, 1'b0, 1'b1, 2, 8'hEE, 1'b0);
        check_eq("write_keep", 32'(ram_data_out), 32'h5A);
        bus_access(20'hA0000, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h99, 1'b0);
        bus_access(20'h00400, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h99, 1'b0);
        bus_access(20'h00400, 8'h3C, 1'b0, 1'b1, 1'b1, 0, 8'h99, 1'b0);
        bus_access(20'h00800, 8'h00, 1'b0, 1'b0, 1'b1, int'(T) - 1, 8'h42, 1'b0);
        check_eq("ack_wins_terr", 32'(timeout_error), 32'd0);
        bus_access(20'h01000, 8'h00, 1'b0, 1'b0, 1'b1, 1000, 8'h00, 1'b0);
        check_eq("timeout_ff", 32'(ram_data_out), 32'hFF);
        bus_access(20'h01000, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h11, 1'b0);
        check_eq("after_to_11", 32'(ram_data_out), 32'h11);
        check_eq("terr_sticky", 32'(timeout_error), 32'd1);
        bus_access(20'h02000, 8'h00, 1'b0, 1'b0, 1'b1, 3, 8'hA7, 1'b1);

        for (int n = 0; n < 60; n++) begin
            logic [19:0] a;
            int d;
            a = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(32'hA0000, 32'hFFFFF))
                                            : 20'($urandom_range(0, 32'h9FFFF));
            d = ($urandom_range(0, 19) == 0) ? 1000 : int'($urandom_range(0, 6));
            bus_access(a, 8'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 7) != 0), d, 8'($urandom),
                       (d >= 2 && d < 10 && $urandom_range(0, 3) == 0));
        end

        // Reset while a read is outstanding
        address = 20'h00100;
        memory_read_n = 1'b0;
        step();
        step();
        check_eq("mid_req", 32'(mem_req), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_req_async", 32'(mem_req), 32'd0);
        exp_rdata = 8'h00;
        exp_terr = 1'b0;
        memory_read_n = 1'b1;
        step();
        #2 reset_n = 1'b1;
        step();
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        step();
        check_idle_outputs("post_rst");
        bus_access(20'h00100, 8'h00, 1'b0, 1'b0, 1'b1, 2, 8'h6B, 1'b0);
        check_eq("post_rst_read", 32'(ram_data_out), 32'h6B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
